fpu_mc: RTL and testbench

Multi-cycle, parametrised floating-point unit, successor to the single-issue `fpu` datapath. It performs add, sub, mul and div on IEEE-754-style operands of configurable exponent/mantissa width. Division uses an iterative restoring divider. Operands enter and results leave through valid/ready handshakes, so the block can sit behind a FIFO or a pipelined issue stage. Exception flags are reported alongside each result.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_mc_div.sv | 63 ++++++
 rtl/fpu_mc.sv | 240 ++++++++++++++++++++++++
 tb/tb_fpu_mc.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared opcodes, FSM states, flag positions and special-value builders for fpu_mc.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_EXEC, S_NORM, S_HOLD} state_e;

  localparam int FL_INV = 3;
  localparam int FL_DVZ = 2;
  localparam int FL_OVF = 1;
  localparam int FL_UNF = 0;

  // Builders return a wide word; callers keep the low 1+exp_w+man_w bits.
  localparam int FP_MAX_W = 64;

  function automatic logic [FP_MAX_W-1:0] fp_zero(input int exp_w, input int man_w, input logic s);
    return FP_MAX_W'(s) << (exp_w + man_w);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w, input logic s);
    logic [FP_MAX_W-1:0] ones;
    ones = (FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1);
    return (ones << man_w) | fp_zero(exp_w, man_w, s);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w, 1'b0) | (FP_MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fpu_mc_div.sv
// Restoring mantissa divider: one quotient bit per cycle, MAN_W+2 bits (integer bit down to guard).
module fpu_div_iter #(
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic             busy,
  output logic             done,
  output logic [MAN_W+1:0] quot
);
  localparam int N  = MAN_W + 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [MAN_W+1:0] rem_q, rem_d, rem_sub;
  logic [MAN_W:0]   dvs_q, dvs_d;
  logic [MAN_W+1:0] quot_q, quot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, ge;

  always_comb begin
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ge      = rem_q >= {1'b0, dvs_q};
    rem_sub = ge ? rem_q - {1'b0, dvs_q} : rem_q;
    if (start) begin
      rem_d  = {1'b0, dividend};
      dvs_d  = divisor;
      quot_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // remainder stays below the divisor, so the shift never loses a bit
      rem_d  = rem_sub << 1;
      quot_d = {quot_q[MAN_W:0], ge};
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
    rem_q  <= rem_d;
    dvs_q  <= dvs_d;
    quot_q <= quot_d;
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);
  assign quot = quot_q;
endmodule

// File: rtl/fpu_mc.sv
// Multi-cycle RZ floating-point unit (add/sub/mul/div) with valid/ready handshakes.
module fpu_mc
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  input  logic [1:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] outp,
  output logic [3:0]           flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M1  = MAN_W + 1;
  localparam int X   = MAN_W + 4;
  localparam int EW2 = EXP_W + 2;
  localparam logic [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);

  function automatic logic [EW2-1:0] lzc(input logic [X-1:0] v);
    lzc = EW2'(X);
    for (int i = 0; i < X; i++) if (v[i]) lzc = EW2'(X - 1 - i);
  endfunction

  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, outp_q, outp_d, spec_res_q, spec_res_d;
  logic [1:0] op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d, sgn_q, sgn_d, spec_q, spec_d;
  logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d, ea_c, eb_c;
  logic [M1-1:0] ma_q, ma_d, mb_q, mb_d, ma_c, mb_c;
  logic [2:0] ca_q, ca_d, cb_q, cb_d, ca_c, cb_c;  // {nan, inf, zero}
  logic [X:0] sum_q, sum_d;
  logic [2*M1-1:0] prod_q, prod_d;
  logic [EW2-1:0] exp_q, exp_d;
  logic [3:0] flags_q, flags_d, spec_fl_q, spec_fl_d;

  // Unpack: denormals flush to zero (mantissa and exponent both cleared)
  assign ea_c = a_q[W-2:MAN_W];
  assign eb_c = b_q[W-2:MAN_W];
  assign ca_c = {&ea_c && |a_q[MAN_W-1:0], &ea_c && a_q[MAN_W-1:0] == '0, ea_c == '0};
  assign cb_c = {&eb_c && |b_q[MAN_W-1:0], &eb_c && b_q[MAN_W-1:0] == '0, eb_c == '0};
  assign ma_c = ca_c[0] ? '0 : {1'b1, a_q[MAN_W-1:0]};
  assign mb_c = cb_c[0] ? '0 : {1'b1, b_q[MAN_W-1:0]};

  logic div_start, div_busy, div_done;
  logic [M1:0] div_quot;
  assign div_start = (state_q == S_UNPACK) && (op_q == OP_DIV);

  fpu_div_iter #(.MAN_W(MAN_W)) u_div (
    .clk(clk), .rst(rst), .start(div_start), .dividend(ma_c), .divisor(mb_c),
    .busy(div_busy), .done(div_done), .quot(div_quot)
  );

  // Execute: aligned add with guard/round/sticky, raw product, exponents, specials
  logic a_big, eff_sub, sticky, nan_in, sp_sgn;
  logic [EXP_W-1:0] e_big, e_sml, shamt;
  logic [M1-1:0] m_big, m_sml;
  logic [X-1:0] ext_sml, al;
  logic [X:0] ex_sum;
  logic [2*M1-1:0] ex_prod;
  logic [EW2-1:0] ex_exp;
  logic ex_sgn, ex_spec;
  logic [1:0] sp_kind;  // 0 qNaN, 1 inf, 2 zero
  logic [3:0] ex_fl;
  logic [FP_MAX_W-1:0] sp_wide;
  logic [W-1:0] ex_res;

  always_comb begin
    a_big   = {ea_q, ma_q} >= {eb_q, mb_q};
    e_big   = a_big ? ea_q : eb_q;
    e_sml   = a_big ? eb_q : ea_q;
    m_big   = a_big ? ma_q : mb_q;
    m_sml   = a_big ? mb_q : ma_q;
    eff_sub = sa_q ^ sb_q;
    shamt   = e_big - e_sml;
    ext_sml = {m_sml, 3'b000};
    if (32'(shamt) >= X) begin
      al     = '0;
      sticky = |m_sml;
    end else begin
      al     = ext_sml >> shamt;
      sticky = |(ext_sml & ~({X{1'b1}} << shamt));
    end
    al[0]   = al[0] | sticky;
    ex_sum  = eff_sub ? {1'b0, m_big, 3'b000} - {1'b0, al} : {1'b0, m_big, 3'b000} + {1'b0, al};
    ex_prod = ma_q * mb_q;
    case (op_q)
      OP_MUL: begin ex_sgn = sa_q ^ sb_q; ex_exp = {2'b00, ea_q} + {2'b00, eb_q} - BIAS; end
      OP_DIV: begin ex_sgn = sa_q ^ sb_q; ex_exp = {2'b00, ea_q} - {2'b00, eb_q} + BIAS; end
      default: begin
        ex_sgn = (ex_sum == '0 && eff_sub) ? 1'b0 : (a_big ? sa_q : sb_q);
        ex_exp = {2'b00, e_big};
      end
    endcase

    ex_spec = 1'b0;
    sp_kind = 2'd0;
    sp_sgn  = sa_q ^ sb_q;
    ex_fl   = '0;
    nan_in  = ca_q[2] | cb_q[2];
    case (op_q)
      OP_MUL: begin
        if (nan_in || (ca_q[0] && cb_q[1]) || (ca_q[1] && cb_q[0])) begin
          ex_spec = 1'b1; ex_fl[FL_INV] = 1'b1;
        end else if (ca_q[1] || cb_q[1]) begin ex_spec = 1'b1; sp_kind = 2'd1; end
        else if (ca_q[0] || cb_q[0]) begin ex_spec = 1'b1; sp_kind = 2'd2; end
      end
      OP_DIV: begin
        if (nan_in || (ca_q[0] && cb_q[0]) || (ca_q[1] && cb_q[1])) begin
          ex_spec = 1'b1; ex_fl[FL_INV] = 1'b1;
        end else if (ca_q[1]) begin ex_spec = 1'b1; sp_kind = 2'd1; end
        else if (cb_q[0]) begin ex_spec = 1'b1; sp_kind = 2'd1; ex_fl[FL_DVZ] = 1'b1; end
        else if (cb_q[1] || ca_q[0]) begin ex_spec = 1'b1; sp_kind = 2'd2; end
      end
      default: begin
        if (nan_in || (ca_q[1] && cb_q[1] && eff_sub)) begin
          ex_spec = 1'b1; ex_fl[FL_INV] = 1'b1;
        end else if (ca_q[1] || cb_q[1]) begin
          ex_spec = 1'b1; sp_kind = 2'd1; sp_sgn = ca_q[1] ? sa_q : sb_q;
        end
      end
    endcase
    case (sp_kind)
      2'd1:    sp_wide = fp_inf(EXP_W, MAN_W, sp_sgn);
      2'd2:    sp_wide = fp_zero(EXP_W, MAN_W, sp_sgn);
      default: sp_wide = fp_qnan(EXP_W, MAN_W);
    endcase
    ex_res = sp_wide[W-1:0];
  end

  // Normalise and pack, truncating (round toward zero)
  logic [EW2-1:0] nm_exp, lz;
  logic [M1-1:0] nm_man;
  logic [X-1:0] shl;
  logic [W-1:0] nm_res;
  logic [3:0] nm_fl;
  logic [FP_MAX_W-1:0] nm_wide;

  always_comb begin
    nm_exp = exp_q;
    nm_man = '0;
    lz     = '0;
    shl    = '0;
    case (op_q)
      OP_MUL: if (prod_q[2*M1-1]) begin nm_man = prod_q[2*M1-1:M1]; nm_exp = exp_q + 1'b1; end
              else nm_man = prod_q[2*M1-2:M1-1];
      OP_DIV: if (div_quot[M1]) nm_man = div_quot[M1:1];
              else begin nm_man = div_quot[M1-1:0]; nm_exp = exp_q - 1'b1; end
      default: if (sum_q[X]) begin nm_man = sum_q[X:4]; nm_exp = exp_q + 1'b1; end
               else begin
                 lz     = lzc(sum_q[X-1:0]);
                 shl    = sum_q[X-1:0] << lz;
                 nm_man = shl[X-1:3];
                 nm_exp = exp_q - lz;
               end
    endcase
    nm_fl   = '0;
    nm_wide = fp_zero(EXP_W, MAN_W, sgn_q);
    nm_res  = nm_wide[W-1:0];
    if (spec_q) begin
      nm_res = spec_res_q;
      nm_fl  = spec_fl_q;
    end else if (!op_q[1] && sum_q == '0) begin
      nm_res = nm_wide[W-1:0];
    end else if (!nm_exp[EW2-1] && nm_exp >= EMAX) begin
      nm_wide        = fp_inf(EXP_W, MAN_W, sgn_q);
      nm_res         = nm_wide[W-1:0];
      nm_fl[FL_OVF]  = 1'b1;
    end else if (nm_exp[EW2-1] || nm_exp == '0) begin
      nm_fl[FL_UNF] = 1'b1;
    end else begin
      nm_res = {sgn_q, nm_exp[EXP_W-1:0], nm_man[MAN_W-1:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d = a_q; b_d = b_q; op_d = op_q;
    sa_d = sa_q; sb_d = sb_q; ea_d = ea_q; eb_d = eb_q;
    ma_d = ma_q; mb_d = mb_q; ca_d = ca_q; cb_d = cb_q;
    sum_d = sum_q; prod_d = prod_q; exp_d = exp_q; sgn_d = sgn_q;
    spec_d = spec_q; spec_res_d = spec_res_q; spec_fl_d = spec_fl_q;
    outp_d = outp_q; flags_d = flags_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d = A; b_d = B; op_d = opcode;
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        sa_d = a_q[W-1];
        sb_d = b_q[W-1] ^ (op_q == OP_SUB);
        ea_d = ca_c[0] ? '0 : ea_c;
        eb_d = cb_c[0] ? '0 : eb_c;
        ma_d = ma_c; mb_d = mb_c; ca_d = ca_c; cb_d = cb_c;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        sum_d = ex_sum; prod_d = ex_prod; exp_d = ex_exp; sgn_d = ex_sgn;
        spec_d = ex_spec; spec_res_d = ex_res; spec_fl_d = ex_fl;
        if (op_q != OP_DIV || (div_busy && div_done)) state_d = S_NORM;
      end
      S_NORM: begin
        outp_d  = nm_res;
        flags_d = nm_fl;
        state_d = S_HOLD;
      end
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      outp_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      outp_q  <= outp_d;
      flags_q <= flags_d;
    end
    a_q <= a_d; b_q <= b_d; op_q <= op_d;
    sa_q <= sa_d; sb_q <= sb_d; ea_q <= ea_d; eb_q <= eb_d;
    ma_q <= ma_d; mb_q <= mb_d; ca_q <= ca_d; cb_q <= cb_d;
    sum_q <= sum_d; prod_q <= prod_d; exp_q <= exp_d; sgn_q <= sgn_d;
    spec_q <= spec_d; spec_res_q <= spec_res_d; spec_fl_q <= spec_fl_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign outp      = outp_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fpu_mc.sv
// Directed-vector bench for fpu_mc at default single-precision widths.
module tb_fpu_mc;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] A, B;
  logic [1:0]  opcode;
  logic        in_ready, out_valid;
  logic [31:0] outp;
  logic [3:0]  flags;

  fpu_mc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .outp(outp), .flags(flags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output logic [31:0] res, output logic [3:0] fl, output int lat);
    int n;
    @(negedge clk);
    A = a; B = b; opcode = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    res = outp;
    fl  = flags;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int          l, n, stale;

    vt[0]  = '{32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, 4'h0, 4};
    vt[1]  = '{32'h40400000, 32'h40400000, 2'b01, 32'h00000000, 4'h0, 4};
    vt[2]  = '{32'h40000000, 32'h40400000, 2'b11, 32'h40C00000, 4'h0, 4};
    vt[3]  = '{32'h7F000000, 32'h7F000000, 2'b11, 32'h7F800000, 4'h2, 4};
    vt[4]  = '{32'h3F800000, 32'h00000000, 2'b10, 32'h7F800000, 4'h4, 28};
    vt[5]  = '{32'h00000000, 32'h00000000, 2'b10, 32'h7FC00000, 4'h8, 28};
    vt[6]  = '{32'h3E13798B, 32'h3EAA79BE, 2'b10, 32'h3EDD75CC, 4'h0, 28};
    vt[7]  = '{32'h3F800000, 32'h40000000, 2'b01, 32'hBF800000, 4'h0, 4};
    vt[8]  = '{32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000, 4'h8, 4};
    vt[9]  = '{32'h00800000, 32'h00800000, 2'b11, 32'h00000000, 4'h1, 4};
    vt[10] = '{32'h40400000, 32'h7F800000, 2'b10, 32'h00000000, 4'h0, 28};
    vt[11] = '{32'h00000001, 32'h3F800000, 2'b00, 32'h3F800000, 4'h0, 4};
    vt[12] = '{32'h00000000, 32'h7F800000, 2'b11, 32'h7FC00000, 4'h8, 4};
    vt[13] = '{32'h40C00000, 32'h40000000, 2'b10, 32'h40400000, 4'h0, 28};
    vt[14] = '{32'h3F800000, 32'h33000000, 2'b01, 32'h3F7FFFFF, 4'h0, 4};
    vt[15] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 4'h2, 4};
    vt[16] = '{32'hC0000000, 32'h40400000, 2'b11, 32'hC0C00000, 4'h0, 4};
    vt[17] = '{32'hBF800000, 32'hBF800000, 2'b01, 32'h00000000, 4'h0, 4};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; opcode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_outp", outp, 32'h0);
    check("rst_flags", {28'b0, flags}, 32'h0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].op, r, f, l);
      check($sformatf("v%0d_outp", i), r, vt[i].res);
      check($sformatf("v%0d_flags", i), {28'b0, f}, {28'b0, vt[i].fl});
      check($sformatf("v%0d_lat", i), l, vt[i].lat);
    end

    // Back-pressure with a pending bundle waiting behind the held result
    @(negedge clk);
    out_ready = 1'b0;
    A = 32'h40000000; B = 32'h40400000; opcode = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'h3F800000; B = 32'h3F800000; opcode = 2'b00;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("bp_reach_hold", {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_outp_%0d", k), outp, 32'h40C00000);
      check($sformatf("bp_in_ready_%0d", k), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp_out_valid_%0d", k), {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after_hs", {31'b0, in_ready}, 32'd1);
    check("bp_no_valid_after_hs", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("bp_pending_accepted", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("bp_pending_outp", outp, 32'h40000000);
    check("bp_pending_lat", n + 1, 32'd4);
    @(posedge clk); #1;

    // Reset in the middle of a division
    @(negedge clk);
    A = 32'h3E13798B; B = 32'h3EAA79BE; opcode = 2'b10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_outp", outp, 32'h0);
    check("mid_rst_flags", {28'b0, flags}, 32'h0);
    @(negedge clk) rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("mid_rst_no_stale", stale, 32'd0);
    run_op(32'h40000000, 32'h40400000, 2'b11, r, f, l);
    check("post_rst_mul_outp", r, 32'h40C00000);
    check("post_rst_mul_flags", {28'b0, f}, 32'h0);
    check("post_rst_mul_lat", l, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
